// File: rtl/regram_fifo.sv
// regram_fifo: synchronous valid/ready FIFO built on a register array.
// The array has one write port and a combinational read port. This module
// controls the array: it owns the pointers, full/empty tracking, flush and
// occupancy.
//
// Optional feature: define REGRAM_FIFO_BYPASS_EN to enable fall-through.
// With fall-through, an entry offered while the FIFO is empty is presented
// on the output in the same cycle. If the consumer takes it in that cycle,
// the entry is never stored.
module regram_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic                          inport_valid_i,
  output logic                          inport_ready_o,
  input  logic [DATA_WIDTH-1:0]         inport_data_i,
  output logic                          outport_valid_o,
  input  logic                          outport_ready_i,
  output logic [DATA_WIDTH-1:0]         outport_data_o,
  output logic [$clog2(DATA_DEPTH):0]   count_o
);

  // Index width, plus one extra wrap bit in each pointer.
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  logic [AW-1:0]         widx;
  logic [AW-1:0]         ridx;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  bypass;
  logic                  wr_en;

  assign widx  = wptr_q[AW-1:0];
  assign ridx  = rptr_q[AW-1:0];
  assign empty = (wptr_q == rptr_q);
  assign full  = (widx == ridx) && (wptr_q[AW] != rptr_q[AW]);

`ifdef REGRAM_FIFO_BYPASS_EN
  // Fall-through applies only when nothing is queued ahead of the new entry.
  assign bypass = empty & inport_valid_i;
`else
  assign bypass = 1'b0;
`endif

  // Ready depends only on state, so there is no combinational ready path.
  assign inport_ready_o  = !full;
  assign outport_valid_o = !empty | bypass;
  assign outport_data_o  = bypass ? inport_data_i : mem_q[ridx];
  assign count_o         = wptr_q - rptr_q;

  assign push = inport_valid_i & inport_ready_o;
  assign pop  = outport_valid_o & outport_ready_i;

  // Next-pointer and write-enable logic. Flush wins over push and pop.
  // A bypassed entry that is consumed in the same cycle leaves no trace.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    wr_en  = 1'b0;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else if (bypass && pop) begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
    end else begin
      if (push) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
    end
  end

  // Pointer registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array. Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[widx] <= inport_data_i;
    end
  end

endmodule

// File: tb/tb_regram_fifo.sv
// Testbench for regram_fifo (DEPTH=4, 8-bit data). The stimulus process
// queues the values it expects to see. A monitor pops that queue on every
// output handshake and compares.
module tb_regram_fifo;

  localparam int DW = 8;
  localparam int DD = 4;

  logic          clk;
  logic          rst_n;
  logic          flush_i;
  logic          inport_valid_i;
  logic          inport_ready_o;
  logic [DW-1:0] inport_data_i;
  logic          outport_valid_o;
  logic          outport_ready_i;
  logic [DW-1:0] outport_data_o;
  logic [2:0]    count_o;

  int checks;
  int failures;
  int rcv_cnt;
  logic [DW-1:0] exp_q[$];

  regram_fifo #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .inport_valid_i  (inport_valid_i),
    .inport_ready_o  (inport_ready_o),
    .inport_data_i   (inport_data_i),
    .outport_valid_o (outport_valid_o),
    .outport_ready_i (outport_ready_i),
    .outport_data_o  (outport_data_o),
    .count_o         (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    inport_valid_i  = v;
    inport_data_i   = d;
    outport_ready_i = r;
    flush_i         = f;
  endtask

  // Monitor: every handshake must match the next expected value.
  always @(negedge clk) begin
    if (rst_n && !flush_i && outport_valid_o && outport_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop: got %0h expected none", outport_data_o);
      end else begin
        if (outport_data_o !== exp_q[0]) begin
          failures++;
          $display("FAIL pop_data: got %0h expected %0h", outport_data_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      rcv_cnt++;
    end
  end

  initial begin
    checks = 0; failures = 0; rcv_cnt = 0;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("reset_count", int'(count_o), 0);
    chk("reset_ready", int'(inport_ready_o), 1);
    chk("reset_valid", int'(outport_valid_o), 0);
    rst_n = 1'b1;

    // Reset mid-operation.
    tick();
    drive(1'b1, 8'h11, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h22, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 chk("pre_rst_count", int'(count_o), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(count_o), 0);
    chk("async_rst_valid", int'(outport_valid_o), 0);
    chk("async_rst_ready", int'(inport_ready_o), 1);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(8'h33);
    drive(1'b1, 8'h33, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 chk("post_rst_count", int'(count_o), 1);
    chk("post_rst_valid", int'(outport_valid_o), 1);
    outport_ready_i = 1'b1; tick();
    outport_ready_i = 1'b0;
    #1 chk("post_rst_drained", int'(count_o), 0);

    // Fill to full; a fifth push must be refused.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hA0 + 8'(i));
      drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0); tick();
    end
    drive(1'b1, 8'hA4, 1'b0, 1'b0);
    #1 chk("full_count", int'(count_o), 4);
    chk("full_ready", int'(inport_ready_o), 0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 chk("full_hold_count", int'(count_o), 4);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (4) tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 chk("drain_valid", int'(outport_valid_o), 0);
    chk("drain_count", int'(count_o), 0);

    // Push and pop together while full: only the pop takes effect.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h50 + 8'(i));
      drive(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0); tick();
    end
    drive(1'b1, 8'hB0, 1'b1, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 chk("full_pushpop_count", int'(count_o), 3);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 chk("full_pushpop_empty", int'(outport_valid_o), 0);

    // Push and pop together at count 2.
    exp_q.push_back(8'h60); exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    drive(1'b1, 8'h60, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h61, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h62, 1'b1, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 chk("mid_pushpop_count", int'(count_o), 2);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 chk("mid_pushpop_empty", int'(count_o), 0);

    // Wrap-around stream of 0..19 with random stalls.
    begin
      int sent;
      int cyc;
      int base;
      int max_cnt;
      sent = 0; cyc = 0; max_cnt = 0;
      base = rcv_cnt;
      for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
      while ((rcv_cnt - base) < 20 && cyc < 600) begin
        drive((sent < 20) && ($urandom_range(0, 3) != 0), 8'(sent),
              $urandom_range(0, 2) != 0, 1'b0);
        #1;
        if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
        if (inport_valid_i && inport_ready_o) sent++;
        tick();
        cyc++;
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("stream_received", rcv_cnt - base, 20);
      checks++;
      if (max_cnt > 4) begin
        failures++;
        $display("FAIL stream_max_count: got %0d expected <= 4", max_cnt);
      end
      #1 chk("stream_empty", int'(outport_valid_o), 0);
    end

    // Flush with a simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h70 + 8'(i));
      drive(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0); tick();
    end
    drive(1'b1, 8'hC0, 1'b1, 1'b1);
    #1 chk("flush_cycle_count", int'(count_o), 3);
    tick();
    exp_q.delete();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 chk("flush_count", int'(count_o), 0);
    chk("flush_valid", int'(outport_valid_o), 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Offer an entry to an empty FIFO with the consumer ready.
    exp_q.push_back(8'hD5);
    drive(1'b1, 8'hD5, 1'b1, 1'b0);
    #1;
`ifdef REGRAM_FIFO_BYPASS_EN
    chk("bypass_valid", int'(outport_valid_o), 1);
    chk("bypass_data", int'(outport_data_o), 8'hD5);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 chk("bypass_count", int'(count_o), 0);
    chk("bypass_after_valid", int'(outport_valid_o), 0);
`else
    chk("nobypass_valid", int'(outport_valid_o), 0);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #1 chk("nobypass_late_valid", int'(outport_valid_o), 1);
    chk("nobypass_late_data", int'(outport_data_o), 8'hD5);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 chk("nobypass_count", int'(count_o), 0);
`endif
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
